// File: rtl/eth_tx_arbiter_if.sv
// Stream bundle between the TX requesters, the arbiter and the RGMII TX input.
// The slave view is the arbiter; the master view is the surrounding logic.
interface eth_tx_arbiter_if #(
  parameter int unsigned N_SRC = 2
);
  logic [N_SRC-1:0]   s_axis_tvalid;
  logic [8*N_SRC-1:0] s_axis_tdata;
  logic [N_SRC-1:0]   s_axis_tlast;
  logic [N_SRC-1:0]   s_axis_tuser;
  logic [N_SRC-1:0]   s_axis_tready;

  logic               tx_axis_tvalid;
  logic [7:0]         tx_axis_tdata;
  logic               tx_axis_tlast;
  logic               tx_axis_tuser;
  logic               tx_axis_tready;

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tuser, tx_axis_tready,
    input  s_axis_tready, tx_axis_tvalid, tx_axis_tdata, tx_axis_tlast, tx_axis_tuser
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tuser, tx_axis_tready,
    output s_axis_tready, tx_axis_tvalid, tx_axis_tdata, tx_axis_tlast, tx_axis_tuser
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Frame-atomic round-robin arbiter in front of the RGMII TX stream, with
// inter-frame gap enforcement and oversize truncation.
module eth_tx_arbiter #(
  parameter int unsigned N_SRC      = 2,
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned MAX_FRAME  = 1522
) (
  input  logic                     clk_int,
  input  logic                     rst_int_n,
  eth_tx_arbiter_if.slave          bus,
  output logic [$clog2(N_SRC)-1:0] grant_idx,
  output logic                     busy,
  output logic [15:0]              frames_sent,
  output logic [7:0]               oversize_cnt
);

  localparam int unsigned GW        = $clog2(N_SRC);
  localparam logic [15:0] LAST_BYTE = 16'(MAX_FRAME - 1);
  localparam logic [7:0]  IFG_LOAD  = 8'(IFG_CYCLES);
  localparam logic        END_BUSY  = (IFG_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, XFER, DROP, GAP} state_t;

  localparam state_t END_STATE = (IFG_CYCLES == 0) ? IDLE : GAP;

  state_t          state;
  logic [GW-1:0]   last_grant;
  logic [15:0]     byte_cnt;
  logic [7:0]      gap_cnt;

  logic            pick_found;
  logic [GW-1:0]   pick_idx;
  logic [GW-1:0]   cand;
  logic            src_valid;
  logic            src_last;
  logic            src_user;
  logic [7:0]      src_data;
  logic            at_limit;
  logic            hs;

  // Round-robin search starting one past the previous winner
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      cand = GW'((32'(last_grant) + k) % N_SRC);
      if (!pick_found && bus.s_axis_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign src_valid = bus.s_axis_tvalid[grant_idx];
  assign src_last  = bus.s_axis_tlast[grant_idx];
  assign src_user  = bus.s_axis_tuser[grant_idx];
  assign src_data  = bus.s_axis_tdata[8*grant_idx +: 8];
  assign at_limit  = (byte_cnt == LAST_BYTE);
  assign hs        = (state == XFER) && src_valid && bus.tx_axis_tready;

  // Unregistered data path: the granted source is muxed straight to the core
  always_comb begin
    bus.tx_axis_tvalid = 1'b0;
    bus.tx_axis_tdata  = '0;
    bus.tx_axis_tlast  = 1'b0;
    bus.tx_axis_tuser  = 1'b0;
    bus.s_axis_tready  = '0;
    case (state)
      XFER: begin
        bus.tx_axis_tvalid           = src_valid;
        bus.tx_axis_tdata            = src_data;
        bus.tx_axis_tlast            = src_last || at_limit;
        bus.tx_axis_tuser            = src_user || (at_limit && !src_last);
        bus.s_axis_tready[grant_idx] = bus.tx_axis_tready;
      end
      DROP:    bus.s_axis_tready[grant_idx] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_int or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state        <= IDLE;
      grant_idx    <= '0;
      last_grant   <= GW'(N_SRC - 1);
      byte_cnt     <= '0;
      gap_cnt      <= '0;
      busy         <= 1'b0;
      frames_sent  <= '0;
      oversize_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_idx  <= pick_idx;
            last_grant <= pick_idx;
            byte_cnt   <= '0;
            busy       <= 1'b1;
            state      <= XFER;
          end
        end
        XFER: begin
          if (hs) begin
            byte_cnt <= byte_cnt + 16'd1;
            if (src_last) begin
              frames_sent <= frames_sent + 16'd1;
              gap_cnt     <= IFG_LOAD;
              busy        <= END_BUSY;
              state       <= END_STATE;
            end else if (at_limit) begin
              if (oversize_cnt != 8'hFF) oversize_cnt <= oversize_cnt + 8'd1;
              state <= DROP;
            end
          end
        end
        DROP: begin
          // Tail of a truncated frame is swallowed up to the source's own tlast
          if (src_valid && src_last) begin
            gap_cnt <= IFG_LOAD;
            busy    <= END_BUSY;
            state   <= END_STATE;
          end
        end
        GAP: begin
          if (gap_cnt <= 8'd1) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: sources and sink are randomized, expected
// frames and grant order come from a frame-level model of the arbitration rules.
module tb_eth_tx_arbiter;

  localparam int unsigned N_SRC = 2;
  localparam int unsigned IFG   = 12;
  localparam int unsigned MAXF  = 100;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  logic        clk_int = 1'b0;
  logic        rst_int_n = 1'b0;
  logic [0:0]  grant_idx;
  logic        busy;
  logic [15:0] frames_sent;
  logic [7:0]  oversize_cnt;

  always #4 clk_int = ~clk_int;

  eth_tx_arbiter_if #(.N_SRC(N_SRC)) bus ();

  eth_tx_arbiter #(
    .N_SRC(N_SRC), .IFG_CYCLES(IFG), .MAX_FRAME(MAXF)
  ) dut (
    .clk_int      (clk_int),
    .rst_int_n    (rst_int_n),
    .bus          (bus),
    .grant_idx    (grant_idx),
    .busy         (busy),
    .frames_sent  (frames_sent),
    .oversize_cnt (oversize_cnt)
  );

  beat_t drv_q[N_SRC][$];
  beat_t exp_q[N_SRC][$];
  int    exp_grant[$];

  int checks = 0;
  int errors = 0;
  int bubble_pct = 0;
  bit rdy_rand = 1'b0;
  bit order_chk = 1'b0;
  bit gap_chk = 1'b0;
  int phase = 0;
  int mdl_frames = 0;
  int mdl_over = 0;
  int mdl_last = N_SRC - 1;
  int seq = 0;
  int out_beats = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue a source frame and its expected (possibly truncated) image on the TX side
  task automatic add_frame(input int s, input int len, input bit bad);
    beat_t b;
    beat_t e;
    for (int i = 0; i < len; i++) begin
      b.d = (i == 0) ? {1'(s), 7'(seq)} : 8'($urandom);
      b.l = (i == len - 1);
      b.u = b.l ? bad : 1'b0;
      drv_q[s].push_back(b);
      if (i < int'(MAXF)) begin
        e = b;
        if (i == int'(MAXF) - 1 && !b.l) begin
          e.l = 1'b1;
          e.u = 1'b1;
        end
        exp_q[s].push_back(e);
      end
    end
    if (len > int'(MAXF)) begin
      if (mdl_over < 255) mdl_over++;
    end else begin
      mdl_frames++;
    end
    seq++;
  endtask

  // Grant order when every source with pending frames keeps tvalid asserted
  task automatic plan_rr(input int c0, input int c1);
    int pend[N_SRC];
    int s;
    pend[0] = c0;
    pend[1] = c1;
    while (pend[0] + pend[1] > 0) begin
      for (int k = 1; k <= int'(N_SRC); k++) begin
        s = (mdl_last + k) % int'(N_SRC);
        if (pend[s] > 0) begin
          exp_grant.push_back(s);
          pend[s]--;
          mdl_last = s;
          break;
        end
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tvalid"}, 64'(bus.tx_axis_tvalid), 64'd0);
    chk({tag, "_tlast"}, 64'(bus.tx_axis_tlast), 64'd0);
    chk({tag, "_tuser"}, 64'(bus.tx_axis_tuser), 64'd0);
    chk({tag, "_tdata"}, 64'(bus.tx_axis_tdata), 64'd0);
    chk({tag, "_s_tready"}, 64'(bus.s_axis_tready), 64'd0);
    chk({tag, "_grant_idx"}, 64'(grant_idx), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_frames_sent"}, 64'(frames_sent), 64'd0);
    chk({tag, "_oversize_cnt"}, 64'(oversize_cnt), 64'd0);
  endtask

  task automatic sync();
    @(posedge clk_int);
    #3;
  endtask

  task automatic drain(input string name);
    int n;
    int pending;
    n = 0;
    pending = 1;
    while ((pending != 0 || busy) && n < 40000) begin
      sync();
      n++;
      pending = exp_grant.size();
      for (int s = 0; s < int'(N_SRC); s++) pending += drv_q[s].size() + exp_q[s].size();
    end
    if (n >= 40000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got pending=%0d busy=%0b expected drained", name, pending, busy);
    end
    repeat (3) sync();
  endtask

  task automatic check_counters(input string name);
    chk({name, "_frames_sent"}, 64'(frames_sent), 64'(16'(mdl_frames)));
    chk({name, "_oversize_cnt"}, 64'(oversize_cnt), 64'(8'(mdl_over)));
    chk({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Source and sink driver: holds each offered beat until it is accepted
  initial begin
    logic [N_SRC-1:0] hs;
    beat_t head;
    bus.s_axis_tvalid  = '0;
    bus.s_axis_tdata   = '0;
    bus.s_axis_tlast   = '0;
    bus.s_axis_tuser   = '0;
    bus.tx_axis_tready = 1'b0;
    forever begin
      @(negedge clk_int);
      hs = bus.s_axis_tvalid & bus.s_axis_tready;
      @(posedge clk_int);
      #1;
      for (int s = 0; s < int'(N_SRC); s++) begin
        if (hs[s] && drv_q[s].size() > 0) void'(drv_q[s].pop_front());
        if (drv_q[s].size() == 0) begin
          bus.s_axis_tvalid[s] = 1'b0;
        end else if (!(bus.s_axis_tvalid[s] && !hs[s])) begin
          head = drv_q[s][0];
          if (int'($urandom_range(99)) >= bubble_pct) begin
            bus.s_axis_tvalid[s]       = 1'b1;
            bus.s_axis_tdata[8*s +: 8] = head.d;
            bus.s_axis_tlast[s]        = head.l;
            bus.s_axis_tuser[s]        = head.u;
          end else begin
            bus.s_axis_tvalid[s] = 1'b0;
          end
        end
      end
      bus.tx_axis_tready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // Monitor: every accepted TX beat is popped against its source's expected frame
  initial begin
    int    cyc;
    int    cur;
    bit    in_frame;
    int    last_fin_cyc;
    int    last_fin_phase;
    bit    prev_stall;
    logic [7:0] prev_d;
    beat_t a;
    beat_t e;
    cyc = 0;
    cur = 0;
    in_frame = 1'b0;
    last_fin_cyc = 0;
    last_fin_phase = -1;
    prev_stall = 1'b0;
    prev_d = '0;
    forever begin
      @(negedge clk_int);
      cyc++;
      if (!rst_int_n) begin
        in_frame   = 1'b0;
        prev_stall = 1'b0;
        out_beats  = 0;
        continue;
      end
      if (prev_stall) begin
        chk("hold_tvalid", 64'(bus.tx_axis_tvalid), 64'd1);
        chk("hold_tdata", 64'(bus.tx_axis_tdata), 64'(prev_d));
      end
      prev_stall = bus.tx_axis_tvalid && !bus.tx_axis_tready;
      prev_d     = bus.tx_axis_tdata;
      if (bus.tx_axis_tvalid && bus.tx_axis_tready) begin
        a.d = bus.tx_axis_tdata;
        a.l = bus.tx_axis_tlast;
        a.u = bus.tx_axis_tuser;
        if (!in_frame) begin
          cur = int'(a.d[7]);
          in_frame = 1'b1;
          out_beats = 0;
          if (order_chk) begin
            if (exp_grant.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL grant_order: got frame from src %0d expected no frame", cur);
            end else begin
              chk("grant_order", 64'(cur), 64'(exp_grant.pop_front()));
            end
          end
          if (gap_chk && last_fin_phase == phase)
            chk("ifg_gap", 64'(cyc - last_fin_cyc), 64'(IFG + 2));
        end
        chk("grant_idx", 64'(grant_idx), 64'(cur));
        if (exp_q[cur].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got data %0h from src %0d expected none", a.d, cur);
        end else begin
          e = exp_q[cur].pop_front();
          chk("beat", 64'(a), 64'(e));
        end
        out_beats++;
        if (a.l) begin
          in_frame = 1'b0;
          last_fin_cyc = cyc;
          last_fin_phase = phase;
        end
      end
    end
  end

  initial begin
    int n;
    rst_int_n = 1'b0;
    repeat (3) @(posedge clk_int);
    #1;
    check_reset_vals("reset");
    @(negedge clk_int);
    rst_int_n = 1'b1;
    repeat (2) sync();

    // Single source, two 64-byte frames back to back at full rate
    phase = 1; order_chk = 1'b1; gap_chk = 1'b1;
    add_frame(0, 64, 1'b0);
    add_frame(0, 64, 1'b0);
    plan_rr(2, 0);
    drain("single");
    check_counters("single");

    // Both sources continuously valid, three frames each
    phase = 2;
    for (int i = 0; i < 3; i++) begin
      add_frame(0, int'($urandom_range(60, 1)), 1'($urandom_range(1)));
      add_frame(1, int'($urandom_range(60, 1)), 1'($urandom_range(1)));
    end
    plan_rr(3, 3);
    drain("alternate");
    check_counters("alternate");

    // Oversize frame followed by a frame of exactly the maximum length
    phase = 3; gap_chk = 1'b0;
    add_frame(1, 150, 1'b0);
    add_frame(1, int'(MAXF), 1'b0);
    plan_rr(0, 2);
    drain("oversize");
    check_counters("oversize");

    // Random sink backpressure and source bubbles
    phase = 4; order_chk = 1'b0; rdy_rand = 1'b1; bubble_pct = 30;
    for (int i = 0; i < 24; i++)
      add_frame(int'($urandom_range(1)), int'($urandom_range(130, 1)), 1'($urandom_range(1)));
    drain("random");
    check_counters("random");

    // Reset in the middle of a frame, then tie-break from reset
    phase = 5; rdy_rand = 1'b0; bubble_pct = 0;
    add_frame(0, 60, 1'b0);
    n = 0;
    while (out_beats < 30 && n < 2000) begin
      @(posedge clk_int);
      #1;
      n++;
    end
    chk("midframe_reached", 64'(out_beats >= 30), 64'd1);
    rst_int_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    for (int s = 0; s < int'(N_SRC); s++) begin
      drv_q[s].delete();
      exp_q[s].delete();
    end
    exp_grant.delete();
    mdl_frames = 0;
    mdl_over = 0;
    mdl_last = N_SRC - 1;
    repeat (3) @(posedge clk_int);
    @(negedge clk_int);
    rst_int_n = 1'b1;
    repeat (2) sync();
    phase = 6; order_chk = 1'b1;
    add_frame(0, 20, 1'b0);
    add_frame(1, 20, 1'b0);
    plan_rr(1, 1);
    drain("post_reset");
    check_counters("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
